// File: rtl/store_data_align.sv
// Store data alignment: turns a store request (address, LSB-justified data,
// size, opcode) into one or two byte-enabled, lane-aligned word writes.
// An access that straddles a word boundary is issued as two back-to-back beats.
module store_data_align #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           dataIn,
    input  logic [2:0]            writeEnable,
    input  logic [6:0]            opcode,
    output logic                  memReq,
    input  logic                  memAck,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [31:0]           memWData,
    output logic [3:0]            memByteEn,
    output logic                  done,
    output logic                  storeErr
);

    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_FPSTORE = 7'b0100111;

    typedef enum logic [1:0] {
        IDLE,
        BEAT0,
        BEAT1
    } stateT;

    stateT                 stateReg;
    logic [3:0]            hiByteEnReg;
    logic [31:0]           hiWDataReg;

    logic [3:0]            sizeMask;
    logic [31:0]           sizeBits;
    logic [7:0]            laneMask8;
    logic [63:0]           data64;
    logic                  legalReq;
    logic [ADDR_WIDTH-1:0] wordAddr;

    // Size decode with word > half > byte priority
    always_comb begin
        sizeMask = 4'b0000;
        if (writeEnable[2]) begin
            sizeMask = 4'b1111;
        end else if (writeEnable[1]) begin
            sizeMask = 4'b0011;
        end else if (writeEnable[0]) begin
            sizeMask = 4'b0001;
        end
    end

    // Expand the byte mask to a bit mask so bytes beyond the access size are zeroed
    for (genvar gi = 0; gi < 4; gi++) begin : gSizeBits
        assign sizeBits[gi*8 +: 8] = {8{sizeMask[gi]}};
    end

    assign laneMask8 = {4'b0000, sizeMask} << addr[1:0];
    assign data64    = {32'h0, dataIn & sizeBits} << {addr[1:0], 3'b000};
    assign legalReq  = ((opcode == OP_STORE) || (opcode == OP_FPSTORE)) && (writeEnable != 3'b000);
    assign wordAddr  = {addr[ADDR_WIDTH-1:2], 2'b00};
    assign reqReady  = (stateReg == IDLE);

    // Request acceptance, beat sequencing and registered bus outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg    <= IDLE;
            memReq      <= 1'b0;
            memAddr     <= '0;
            memWData    <= 32'h0;
            memByteEn   <= 4'b0000;
            hiByteEnReg <= 4'b0000;
            hiWDataReg  <= 32'h0;
            done        <= 1'b0;
            storeErr    <= 1'b0;
        end else begin
            done     <= 1'b0;
            storeErr <= 1'b0;
            case (stateReg)
                IDLE: begin
                    if (reqValid) begin
                        if (!legalReq) begin
                            storeErr <= 1'b1;
                        end else if (laneMask8[3:0] != 4'b0000) begin
                            stateReg    <= BEAT0;
                            memReq      <= 1'b1;
                            memAddr     <= wordAddr;
                            memByteEn   <= laneMask8[3:0];
                            memWData    <= data64[31:0];
                            hiByteEnReg <= laneMask8[7:4];
                            hiWDataReg  <= data64[63:32];
                        end else begin
                            // Nothing lands in the first word: go straight to the upper beat
                            stateReg    <= BEAT1;
                            memReq      <= 1'b1;
                            memAddr     <= wordAddr + ADDR_WIDTH'(4);
                            memByteEn   <= laneMask8[7:4];
                            memWData    <= data64[63:32];
                            hiByteEnReg <= 4'b0000;
                            hiWDataReg  <= 32'h0;
                        end
                    end
                end
                BEAT0: begin
                    if (memAck) begin
                        if (hiByteEnReg != 4'b0000) begin
                            stateReg  <= BEAT1;
                            memAddr   <= memAddr + ADDR_WIDTH'(4);
                            memByteEn <= hiByteEnReg;
                            memWData  <= hiWDataReg;
                        end else begin
                            stateReg  <= IDLE;
                            memReq    <= 1'b0;
                            memByteEn <= 4'b0000;
                            memWData  <= 32'h0;
                            done      <= 1'b1;
                        end
                    end
                end
                BEAT1: begin
                    if (memAck) begin
                        stateReg  <= IDLE;
                        memReq    <= 1'b0;
                        memByteEn <= 4'b0000;
                        memWData  <= 32'h0;
                        done      <= 1'b1;
                    end
                end
                default: begin
                    stateReg <= IDLE;
                    memReq   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_data_align.sv
// Bench for store_data_align: byte-level transaction model plus directed
// literal expectations and a randomized phase with random bus back-pressure.
module tb_store_data_align;

    localparam logic [6:0] OP_S  = 7'b0100011;
    localparam logic [6:0] OP_FS = 7'b0100111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reqValid = 1'b0;
    logic        reqReady;
    logic [31:0] addr = 32'h0;
    logic [31:0] dataIn = 32'h0;
    logic [2:0]  writeEnable = 3'b000;
    logic [6:0]  opcode = 7'h0;
    logic        memReq;
    logic        memAck = 1'b0;
    logic [31:0] memAddr;
    logic [31:0] memWData;
    logic [3:0]  memByteEn;
    logic        done;
    logic        storeErr;

    int nVec = 0;
    int nMis = 0;
    int ackMode = 0;   // 0: always ack, 1: random ack, 2: ack in 4th cycle of each beat
    int holdCnt = 0;

    typedef struct {
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] d;
    } beatT;

    beatT modelQ[$];
    logic expDone = 1'b0;
    logic expErr  = 1'b0;

    store_data_align #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .reqValid(reqValid), .reqReady(reqReady),
        .addr(addr), .dataIn(dataIn), .writeEnable(writeEnable), .opcode(opcode),
        .memReq(memReq), .memAck(memAck), .memAddr(memAddr), .memWData(memWData),
        .memByteEn(memByteEn), .done(done), .storeErr(storeErr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Byte-by-byte model: each stored byte goes to byte address addr+i; bytes
    // sharing a word form one beat, beats issued in ascending address order.
    task automatic modelAccept(input logic [31:0] a, input logic [31:0] dd, input logic [2:0] we);
        int n;
        logic [31:0] ba;
        logic [31:0] w;
        logic [1:0]  lane;
        beatT        tmp;
        n = we[2] ? 4 : (we[1] ? 2 : 1);
        for (int i = 0; i < n; i++) begin
            ba   = a + 32'(i);
            w    = {ba[31:2], 2'b00};
            lane = ba[1:0];
            if (modelQ.size() == 0 || modelQ[modelQ.size()-1].a != w) begin
                tmp.a  = w;
                tmp.be = 4'b0000;
                tmp.d  = 32'h0;
                modelQ.push_back(tmp);
            end
            tmp = modelQ[modelQ.size()-1];
            tmp.be[lane] = 1'b1;
            tmp.d[lane*8 +: 8] = dd[i*8 +: 8];
            modelQ[modelQ.size()-1] = tmp;
        end
    endtask

    // Every negedge: compare DUT to the model, then advance the model with the
    // inputs that the coming posedge will sample (inputs change only at posedge+2).
    always @(negedge clk) begin
        if (!rst_n) begin
            modelQ.delete();
            expDone = 1'b0;
            expErr  = 1'b0;
        end else begin
            logic expReq;
            logic dN;
            logic eN;
            expReq = (modelQ.size() != 0);
            chk("reqReady", 32'(reqReady), 32'(!expReq));
            chk("memReq", 32'(memReq), 32'(expReq));
            chk("done", 32'(done), 32'(expDone));
            chk("storeErr", 32'(storeErr), 32'(expErr));
            if (expReq) begin
                chk("memAddr", memAddr, modelQ[0].a);
                chk("memByteEn", 32'(memByteEn), 32'(modelQ[0].be));
                chk("memWData", memWData, modelQ[0].d);
            end
            dN = 1'b0;
            eN = 1'b0;
            if (!expReq) begin
                if (reqValid) begin
                    if ((opcode == OP_S || opcode == OP_FS) && writeEnable != 3'b000)
                        modelAccept(addr, dataIn, writeEnable);
                    else
                        eN = 1'b1;
                end
            end else if (memAck) begin
                void'(modelQ.pop_front());
                if (modelQ.size() == 0) dN = 1'b1;
            end
            expDone = dN;
            expErr  = eN;
        end
    end

    // Bus acknowledge generator
    always @(posedge clk) begin
        #2;
        if (ackMode == 0) begin
            memAck = 1'b1;
        end else if (ackMode == 1) begin
            memAck = 1'($urandom % 2);
        end else if (!memReq) begin
            holdCnt = 0;
            memAck  = 1'b0;
        end else begin
            if (memAck) holdCnt = 1;
            else holdCnt++;
            memAck = (holdCnt >= 4);
        end
    end

    // Present one request for one cycle once the block is ready; returns at
    // posedge+2 of the cycle after acceptance, with the request inputs scrambled.
    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [2:0] we, input logic [6:0] op);
        int waitCnt;
        @(posedge clk);
        #2;
        waitCnt = 0;
        while (!reqReady && waitCnt < 200) begin
            @(posedge clk);
            #2;
            waitCnt++;
        end
        if (!reqReady) chk("issueTimeout", 32'(reqReady), 32'd1);
        $display("req addr=%h data=%h we=%b op=%b", a, d, we, op);
        reqValid    = 1'b1;
        addr        = a;
        dataIn      = d;
        writeEnable = we;
        opcode      = op;
        @(posedge clk);
        #2;
        reqValid    = 1'b0;
        addr        = $urandom;
        dataIn      = $urandom;
        writeEnable = 3'($urandom);
        opcode      = 7'($urandom);
    endtask

    task automatic expectBeat(input string name, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        @(negedge clk);
        chk({name, ".memReq"}, 32'(memReq), 32'd1);
        chk({name, ".reqReady"}, 32'(reqReady), 32'd0);
        chk({name, ".memAddr"}, memAddr, a);
        chk({name, ".memByteEn"}, 32'(memByteEn), 32'(be));
        chk({name, ".memWData"}, memWData, d);
        chk({name, ".done"}, 32'(done), 32'd0);
    endtask

    task automatic expectDone(input string name);
        @(negedge clk);
        chk({name, ".done"}, 32'(done), 32'd1);
        chk({name, ".memReq"}, 32'(memReq), 32'd0);
        chk({name, ".reqReady"}, 32'(reqReady), 32'd1);
    endtask

    task automatic waitIdle();
        int c;
        c = 0;
        while (!reqReady && c < 500) begin
            @(posedge clk);
            c++;
        end
        chk("idleTimeout", 32'(reqReady), 32'd1);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        logic [31:0] ra;
        logic [6:0]  rop;
        int          r;

        // Reset state
        #1;
        chk("rst.memReq", 32'(memReq), 32'd0);
        chk("rst.reqReady", 32'(reqReady), 32'd1);
        chk("rst.memByteEn", 32'(memByteEn), 32'd0);
        chk("rst.memWData", memWData, 32'd0);
        chk("rst.memAddr", memAddr, 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.storeErr", 32'(storeErr), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // 1: aligned word, zero-wait ack
        ackMode = 0;
        issue(32'h100, 32'hDEADBEEF, 3'b100, OP_S);
        expectBeat("t1", 32'h100, 4'b1111, 32'hDEADBEEF);
        expectDone("t1");
        @(negedge clk);
        chk("t1.donePulse", 32'(done), 32'd0);

        // 2: byte at offset 3
        issue(32'h103, 32'hFFFFFFA5, 3'b001, OP_S);
        expectBeat("t2", 32'h100, 4'b1000, 32'hA5000000);
        expectDone("t2");

        // 3: half at offset 2, then split half at offset 3
        issue(32'h202, 32'hABCD1234, 3'b010, OP_FS);
        expectBeat("t3a", 32'h200, 4'b1100, 32'h12340000);
        expectDone("t3a");
        issue(32'h403, 32'hABCD1234, 3'b010, OP_S);
        expectBeat("t3b0", 32'h400, 4'b1000, 32'h34000000);
        expectBeat("t3b1", 32'h404, 4'b0001, 32'h00000012);
        expectDone("t3b");

        // 4: misaligned word, ack in 4th cycle of each beat
        ackMode = 2;
        issue(32'h301, 32'h11223344, 3'b100, OP_S);
        for (int i = 0; i < 4; i++) expectBeat("t4b0", 32'h300, 4'b1110, 32'h22334400);
        for (int i = 0; i < 4; i++) expectBeat("t4b1", 32'h304, 4'b0001, 32'h00000011);
        expectDone("t4");

        // 5: illegal requests
        ackMode = 0;
        issue(32'h500, 32'h12345678, 3'b100, 7'b0000011);
        @(negedge clk);
        chk("t5a.storeErr", 32'(storeErr), 32'd1);
        chk("t5a.memReq", 32'(memReq), 32'd0);
        chk("t5a.reqReady", 32'(reqReady), 32'd1);
        issue(32'h500, 32'h12345678, 3'b000, OP_S);
        @(negedge clk);
        chk("t5b.storeErr", 32'(storeErr), 32'd1);
        chk("t5b.memReq", 32'(memReq), 32'd0);
        @(negedge clk);
        chk("t5b.errPulse", 32'(storeErr), 32'd0);

        // 6: reset during the second beat of a split word store
        ackMode = 2;
        issue(32'h301, 32'h11223344, 3'b100, OP_S);
        for (int i = 0; i < 4; i++) expectBeat("t6b0", 32'h300, 4'b1110, 32'h22334400);
        expectBeat("t6b1", 32'h304, 4'b0001, 32'h00000011);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6.memReq", 32'(memReq), 32'd0);
        chk("t6.memByteEn", 32'(memByteEn), 32'd0);
        chk("t6.memWData", memWData, 32'd0);
        chk("t6.done", 32'(done), 32'd0);
        chk("t6.reqReady", 32'(reqReady), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        ackMode = 0;
        @(negedge clk);
        chk("t6.noDone", 32'(done), 32'd0);
        issue(32'h100, 32'hCAFEF00D, 3'b111, OP_S);
        expectBeat("t6w", 32'h100, 4'b1111, 32'hCAFEF00D);
        expectDone("t6w");

        // Randomized phase with random back-pressure, checked by the model
        ackMode = 1;
        for (int k = 0; k < 400; k++) begin
            r = int'($urandom % 8);
            ra = (r == 0) ? (32'hFFFFFFFC | 32'($urandom % 4)) : $urandom;
            r = int'($urandom % 8);
            rop = (r < 4) ? OP_S : (r < 6) ? OP_FS : (r == 6) ? 7'($urandom) : 7'b0000011;
            repeat ($urandom % 3) @(posedge clk);
            issue(ra, $urandom, 3'($urandom), rop);
        end
        waitIdle();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule

// File: doc/store_data_align.md
Name: store_data_align

Overview:
- Store-side counterpart of the load data-extension path: takes a store request (address, register data, access size, opcode) and turns it into one or two byte-enabled, lane-aligned word writes on the data-memory bus.
- Handles byte, half and word stores at any byte offset. An access that crosses a word boundary is split into two sequential bus beats.
- Sits between the LSU issue stage and the data-memory port.
- Uses the same size encoding (3-bit one-hot-ish enable) and the same opcode qualification as the load path.

Parameters:
- ADDR_WIDTH, 32, width of addr/memAddr (minimum 3).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- reqValid  input  1  store request valid
- reqReady  output  1  block can accept a request
- addr  input  ADDR_WIDTH  byte address of store
- dataIn  input  32  store data, LSB-justified
- writeEnable  input  3  size: bit2 word, bit1 half, bit0 byte
- opcode  input  7  instruction opcode
- memReq  output  1  bus write request
- memAck  input  1  bus write accepted
- memAddr  output  ADDR_WIDTH  word-aligned write address
- memWData  output  32  lane-aligned write data
- memByteEn  output  4  byte-lane enables
- done  output  1  one-cycle pulse: store fully written
- storeErr  output  1  one-cycle pulse: request rejected

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state IDLE, reqReady 1, memReq 0, memAddr 0, memWData 0, memByteEn 0, done 0, storeErr 0.
- Reset asserted mid-operation drops memReq immediately. Any in-flight beat is abandoned and done is not pulsed.
- States: IDLE, BEAT0, BEAT1.
- reqReady = (state == IDLE), combinational. A request is accepted on a clk edge where reqValid & reqReady.
- Legal request: opcode is 7'b0100011 or 7'b0100111, and writeEnable != 0.
- Illegal request at accept: storeErr pulses high in the next cycle, state stays IDLE, no memReq.
- Size priority: writeEnable[2] selects word (mask 4'b1111), else [1] selects half (4'b0011), else [0] selects byte (4'b0001).
- Let off = addr[1:0].
- 8-bit mask m8 = mask << off.
- 64-bit data d64 = (dataIn & size-mask expanded to bits) << (8*off). Bytes of dataIn outside the access size are zeroed.
- Lanes that are not enabled carry 0 in memWData.
- Accept (legal) -> BEAT0 in the next cycle. Outputs are registered:
  - memReq = 1
  - memAddr = {addr[ADDR_WIDTH-1:2], 2'b00}
  - memByteEn = m8[3:0]
  - memWData = d64[31:0]
- If m8[3:0] == 0 (possible only if size/offset logic changes), BEAT0 is skipped and the block goes directly to BEAT1. With the current encoding this never occurs.
- While memReq = 1, memAddr/memWData/memByteEn are held stable until memAck is sampled high. memAck is ignored while memReq = 0.
- BEAT0 with memAck:
  - If m8[7:4] != 0: go to BEAT1 with memAddr = previous memAddr + 4 (wraps modulo 2^ADDR_WIDTH), memByteEn = m8[7:4], memWData = d64[63:32]. memReq stays 1 with no idle gap.
  - Otherwise: go to IDLE, memReq = 0, done pulses in the same cycle the block re-enters IDLE.
- BEAT1 with memAck: go to IDLE, memReq = 0, done pulses.
- Latency:
  - Aligned store with zero-wait ack: accept at edge N, memReq high in cycle N+1, ack sampled at edge N+1, done high in cycle N+2.
  - Split store adds one beat.
- A new request may be accepted in the same cycle done is high, because reqReady = 1 in IDLE.
- Request inputs are latched at accept. Later changes to addr/dataIn have no effect on the store in flight.

Test Plan:
1. Word store, addr=0x100, dataIn=0xDEADBEEF, memAck tied 1 -> one beat: memAddr 0x100, memByteEn 4'b1111, memWData 0xDEADBEEF; done one cycle later; memReq high for exactly 1 cycle.
2. Byte store, addr=0x103, dataIn=0xFFFFFFA5 -> memAddr 0x100, memByteEn 4'b1000, memWData 0xA5000000.
3. Half store, addr=0x202, dataIn=0xABCD1234 -> memAddr 0x200, memByteEn 4'b1100, memWData 0x12340000. Then addr=0x403 -> beat0 0x400/4'b1000/0x34000000, beat1 0x404/4'b0001/0x00000012, single done after beat1.
4. Misaligned word store, addr=0x301, dataIn=0x11223344, memAck delayed 3 cycles per beat -> beat0 0x300/4'b1110/0x22334400 held stable 4 cycles, then beat1 0x304/4'b0001/0x00000011; reqReady low throughout.
5. Illegal requests, opcode=7'b0000011 or writeEnable=0 -> storeErr one-cycle pulse, memReq never rises, reqReady stays 1.
6. rst_n pulled low during BEAT1 of case 4 -> memReq, memByteEn, memWData go to 0 asynchronously, no done; after release a word store to 0x100 completes normally.
